// File: rtl/breakout_pkg.sv
// Shared breakout definitions used by the collision detector, game_logic and
// the renderer: screen geometry, default ball size, side-flag indices, the
// beam-position record carried through the obstacle alignment delay, and a
// saturating 4-bit counter helper.
package breakout_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int BALL_SIZE = 4;

  // Bit positions of the side-match vector
  localparam int TOP    = 0;
  localparam int BOTTOM = 1;
  localparam int LEFT   = 2;
  localparam int RIGHT  = 3;

  typedef struct packed {
    logic       valid;  // beam inside the visible area
    logic [9:0] hpos;
    logic [9:0] vpos;
  } beam_pos_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic inc);
    return (inc && cnt != 4'hF) ? cnt + 4'd1 : cnt;
  endfunction

endpackage

// File: rtl/ball_collision_detector_pos_delay_line.sv
// pos_delay_line: delays the beam position record by DEPTH cycles so it lines
// up with the renderer's obstacle sample. DEPTH==0 is a plain wire.
// Ports:
//   clk, nRst  clock, async active-low reset (clears every stage incl. valid)
//   din        beam position record at presentation time
//   dout       the same record DEPTH cycles later
module pos_delay_line import breakout_pkg::*; #(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      nRst,
  input  beam_pos_t din,
  output beam_pos_t dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      beam_pos_t [DEPTH-1:0] pipe_q;

      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign dout = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ball_collision_detector.sv
// ball_collision_detector: classifies obstacle pixels on the one-pixel ring
// around the ball box as top/bottom/left/right contacts and emits a registered
// collision strobe with side flags. Also produces the once-per-frame
// frame_pulse and a saturating per-frame contact count.
// Ports:
//   clk, nRst          clock, async active-low reset
//   hpos, vpos         beam position
//   ball_x, ball_y     ball top-left from game_logic (sampled during blanking)
//   obstacle           obstacle pixel, OBSTACLE_LATENCY cycles after hpos/vpos
//   frame_pulse        one-cycle strobe after (0, FRAME_PULSE_LINE) is sampled
//   collision          one-cycle contact strobe
//   ball_*_col         side of the contact (at most one set per strobe)
//   hit_count          contacts counted in the previous frame, saturating at 15
module ball_collision_detector #(
  parameter int BALL_SIZE        = breakout_pkg::BALL_SIZE,
  parameter int H_VISIBLE        = breakout_pkg::H_VISIBLE,
  parameter int V_VISIBLE        = breakout_pkg::V_VISIBLE,
  parameter int FRAME_PULSE_LINE = 480,
  parameter int OBSTACLE_LATENCY = 1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic       obstacle,
  output logic       frame_pulse,
  output logic       collision,
  output logic       ball_top_col,
  output logic       ball_bottom_col,
  output logic       ball_left_col,
  output logic       ball_right_col,
  output logic [3:0] hit_count
);
  import breakout_pkg::*;

  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
  localparam logic [10:0] BS      = 11'(BALL_SIZE);
  localparam logic [9:0]  FP_LINE = 10'(FRAME_PULSE_LINE);

  // ---------------- beam alignment ----------------
  logic [10:0] hpos_w, vpos_w;
  beam_pos_t   cur_pos, aln_pos;

  assign hpos_w  = {1'b0, hpos};
  assign vpos_w  = {1'b0, vpos};
  assign cur_pos = '{valid: (hpos_w < H_VIS) && (vpos_w < V_VIS), hpos: hpos, vpos: vpos};

  pos_delay_line #(.DEPTH(OBSTACLE_LATENCY)) u_delay (
    .clk  (clk),
    .nRst (nRst),
    .din  (cur_pos),
    .dout (aln_pos)
  );

  // ---------------- ball snapshot ----------------
  // Frozen through the visible area so a mid-frame ball update cannot split
  // one frame's contacts across two positions.
  logic [9:0] snap_x;
  logic [8:0] snap_y;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      snap_x <= '0;
      snap_y <= '0;
    end else if (vpos_w >= V_VIS) begin
      snap_x <= ball_x;
      snap_y <= ball_y;
    end
  end

  // ---------------- classification ----------------
  // 11-bit arithmetic: written as ay+1==sy rather than ay==sy-1 so a ball at
  // line/column 0 never matches a top/left contact, and sx+BS past the screen
  // edge simply never matches a visible pixel.
  logic [10:0] ax, ay, sx, sy, x_last, y_last;
  logic        in_cols, in_rows;
  logic [3:0]  side;
  logic        hit;

  assign ax     = {1'b0, aln_pos.hpos};
  assign ay     = {1'b0, aln_pos.vpos};
  assign sx     = {1'b0, snap_x};
  assign sy     = {2'b0, snap_y};
  assign x_last = sx + BS - 11'd1;
  assign y_last = sy + BS - 11'd1;

  assign in_cols = (ax >= sx) && (ax <= x_last);
  assign in_rows = (ay >= sy) && (ay <= y_last);

  // Ring corners fall outside both ranges, so they match no side.
  always_comb begin
    side         = '0;
    side[TOP]    = (ay + 11'd1 == sy) && in_cols;
    side[BOTTOM] = (ay == sy + BS)    && in_cols;
    side[LEFT]   = (ax + 11'd1 == sx) && in_rows;
    side[RIGHT]  = (ax == sx + BS)    && in_rows;
  end

  // armed stays low from reset until the first frame_pulse, so a contact
  // interrupted by reset cannot resurface against the cleared snapshot.
  logic armed;

  assign hit = armed && aln_pos.valid && obstacle && (|side);

  // ---------------- outputs, frame pulse, counting ----------------
  logic       fire_frame;
  logic [3:0] run_cnt, cnt_next;

  assign fire_frame = (hpos == 10'd0) && (vpos == FP_LINE);
  assign cnt_next   = sat_inc(run_cnt, collision);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      collision       <= 1'b0;
      ball_top_col    <= 1'b0;
      ball_bottom_col <= 1'b0;
      ball_left_col   <= 1'b0;
      ball_right_col  <= 1'b0;
      frame_pulse     <= 1'b0;
      hit_count       <= '0;
      run_cnt         <= '0;
      armed           <= 1'b0;
    end else begin
      collision       <= hit;
      ball_top_col    <= hit && side[TOP];
      ball_bottom_col <= hit && side[BOTTOM];
      ball_left_col   <= hit && side[LEFT];
      ball_right_col  <= hit && side[RIGHT];
      frame_pulse     <= fire_frame;
      armed           <= armed || fire_frame;
      if (fire_frame) begin
        hit_count <= cnt_next;
        run_cnt   <= '0;
      end else begin
        run_cnt   <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_ball_collision_detector.sv
// Bench for ball_collision_detector: drives compressed beam sweeps (windows
// around the ball plus short blanking bursts), an obstacle map delayed by the
// obstacle latency, and checks every cycle against a geometric model; directed
// frames pin the model with hand-derived counts, latencies and hit_count values.
module tb_ball_collision_detector;
  import breakout_pkg::*;

  localparam int L = 1;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic [9:0] hpos = '0, vpos = '0, ball_x = '0;
  logic [8:0] ball_y = '0;
  logic       obstacle = 1'b0;
  logic       frame_pulse, collision, ball_top_col, ball_bottom_col;
  logic       ball_left_col, ball_right_col;
  logic [3:0] hit_count;

  ball_collision_detector #(
    .BALL_SIZE(B), .H_VISIBLE(640), .V_VISIBLE(480),
    .FRAME_PULSE_LINE(480), .OBSTACLE_LATENCY(L)
  ) dut (
    .clk(clk), .nRst(nRst), .hpos(hpos), .vpos(vpos), .ball_x(ball_x),
    .ball_y(ball_y), .obstacle(obstacle), .frame_pulse(frame_pulse),
    .collision(collision), .ball_top_col(ball_top_col),
    .ball_bottom_col(ball_bottom_col), .ball_left_col(ball_left_col),
    .ball_right_col(ball_right_col), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int key(input int x, input int y);
    return y * 1024 + x;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Which side of the ball box (sx,sy) a visible pixel key touches
  function automatic logic [3:0] contact(input int k, input int sx, input int sy);
    int x, y;
    logic [3:0] s;
    x = k % 1024;
    y = k / 1024;
    s = '0;
    if (x >= 640 || y >= 480) return s;
    s[TOP]    = (y == sy - 1) && (x >= sx) && (x < sx + B);
    s[BOTTOM] = (y == sy + B) && (x >= sx) && (x < sx + B);
    s[LEFT]   = (x == sx - 1) && (y >= sy) && (y < sy + B);
    s[RIGHT]  = (x == sx + B) && (y >= sy) && (y < sy + B);
    return s;
  endfunction

  // ---------------- reference model ----------------
  int         mh[$];
  logic [3:0] e_sides = '0;
  logic       e_coll;
  logic       e_fp = 1'b0;
  logic [3:0] e_hit = '0;
  int         m_cnt = 0;
  bit         m_armed = 0;
  int         m_sx = 0, m_sy = 0;

  assign e_coll = |e_sides;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      e_sides <= '0; e_fp <= 1'b0; e_hit <= '0;
      m_cnt <= 0; m_armed <= 0; m_sx <= 0; m_sy <= 0;
      mh.delete();
    end else begin
      mh.push_front(key(int'(hpos), int'(vpos)));
      if (mh.size() > L + 1) void'(mh.pop_back());
      e_sides <= (m_armed && obstacle && mh.size() > L) ? contact(mh[L], m_sx, m_sy) : 4'd0;
      e_fp    <= (hpos == 0 && vpos == 480);
      if (hpos == 0 && vpos == 480) begin
        e_hit   <= 4'(sat15(m_cnt + int'(e_coll)));
        m_cnt   <= 0;
        m_armed <= 1;
      end else begin
        m_cnt   <= sat15(m_cnt + int'(e_coll));
      end
      if (vpos >= 480) begin
        m_sx <= int'(ball_x);
        m_sy <= int'(ball_y);
      end
    end
  end

  // ---------------- checking / monitoring ----------------
  int tests = 0, fails = 0;
  int n_coll, n_top, n_bot, n_left, n_right, n_fp;
  int last_coll_cyc = -1, fp_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr();
    n_coll = 0; n_top = 0; n_bot = 0; n_left = 0; n_right = 0; n_fp = 0;
  endtask

  task automatic compare_cycle();
    check("collision", collision, e_coll);
    check("top", ball_top_col, e_sides[TOP]);
    check("bottom", ball_bottom_col, e_sides[BOTTOM]);
    check("left", ball_left_col, e_sides[LEFT]);
    check("right", ball_right_col, e_sides[RIGHT]);
    check("frame_pulse", frame_pulse, e_fp);
    check("hit_count", hit_count, e_hit);
    check("fp_coll_exclusive", frame_pulse & collision, 0);
    if (collision) begin
      n_coll++; last_coll_cyc = cyc;
      n_top += ball_top_col; n_bot += ball_bottom_col;
      n_left += ball_left_col; n_right += ball_right_col;
    end
    if (frame_pulse) begin n_fp++; fp_cyc = cyc; end
  endtask

  // ---------------- stimulus ----------------
  bit obs_set[int];
  int hq[$];
  int chg_line = -1, chg_x = 0;
  int mark_key = -1, mark_cyc = 0, t_fp0 = 0;
  int rst_key = -1;
  bit rst_pending = 0;

  task automatic drive(input int h, input int v);
    @(negedge clk);
    compare_cycle();
    if (rst_pending) begin
      rst_pending = 0;
      #2 nRst = 1'b0;
      #1;
      check("rst_collision", collision, 0);
      check("rst_sides", {ball_top_col, ball_bottom_col, ball_left_col, ball_right_col}, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_frame_pulse", frame_pulse, 0);
      repeat (2) begin @(negedge clk); compare_cycle(); end
      #2 nRst = 1'b1;
      clr();
    end
    hpos = 10'(h);
    vpos = 10'(v);
    if (v == chg_line) ball_x = 10'(chg_x);
    hq.push_front(key(h, v));
    if (hq.size() > L + 1) void'(hq.pop_back());
    obstacle = (hq.size() > L) && obs_set.exists(hq[L]);
    if (key(h, v) == mark_key) mark_cyc = cyc;
    if (h == 0 && v == 480) t_fp0 = cyc;
    if (key(h, v) == rst_key) rst_pending = 1;
  endtask

  task automatic window(input int xlo, input int xhi, input int ylo, input int yhi);
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) drive(x, y);
      repeat (6) drive(700, y);  // horizontal blanking keeps pulses apart
    end
  endtask

  task automatic blank();
    for (int v = 480; v <= 481; v++)
      for (int h = 0; h < 16; h++) drive(h, v);
  endtask

  task automatic set_ball(input int x, input int y);
    ball_x = 10'(x);
    ball_y = 9'(y);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bx, by;
    clr();
    #2 nRst = 1'b0;
    #1;
    check("reset_collision", collision, 0);
    check("reset_frame_pulse", frame_pulse, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_sides", {ball_top_col, ball_bottom_col, ball_left_col, ball_right_col}, 0);
    repeat (2) begin @(negedge clk); compare_cycle(); end
    #2 nRst = 1'b1;

    set_ball(100, 200);
    blank();

    // 1: single top contact, latency 2 from presentation
    obs_set.delete(); obs_set[key(101, 199)] = 1;
    mark_key = key(101, 199);
    clr(); window(95, 110, 196, 207);
    check("t1_pulses", n_coll, 1);
    check("t1_top", n_top, 1);
    check("t1_other_sides", n_bot + n_left + n_right, 0);
    check("t1_latency", last_coll_cyc - mark_cyc, 2);
    mark_key = -1;
    clr(); blank();
    check("t1_hit_count", hit_count, 1);
    check("t1_fp_once", n_fp, 1);
    check("t1_fp_latency", fp_cyc - t_fp0, 1);

    // 2: right, left, bottom
    obs_set.delete();
    obs_set[key(104, 201)] = 1; obs_set[key(99, 202)] = 1; obs_set[key(102, 204)] = 1;
    clr(); window(95, 110, 196, 207);
    check("t2_pulses", n_coll, 3);
    check("t2_right", n_right, 1);
    check("t2_left", n_left, 1);
    check("t2_bottom", n_bot, 1);
    check("t2_top", n_top, 0);
    blank();
    check("t2_hit_count", hit_count, 3);

    // 3: corners and interior never match
    obs_set.delete();
    obs_set[key(99, 199)] = 1; obs_set[key(104, 204)] = 1; obs_set[key(101, 201)] = 1;
    clr(); window(95, 110, 196, 207);
    check("t3_pulses", n_coll, 0);
    set_ball(0, 0);
    blank();
    check("t3_hit_count", hit_count, 0);

    // 4: ball at origin; line 0 and column 0 filled. No top/left can match;
    // (4,0) lies on the right ring and (0,4) on the bottom ring.
    obs_set.delete();
    for (int i = 0; i < 16; i++) begin obs_set[key(i, 0)] = 1; obs_set[key(0, i)] = 1; end
    clr(); window(0, 15, 0, 15);
    check("t4_top", n_top, 0);
    check("t4_left", n_left, 0);
    check("t4_right", n_right, 1);
    check("t4_bottom", n_bot, 1);
    set_ball(100, 200);
    blank();
    check("t4_hit_count", hit_count, 2);

    // 5: mid-frame ball_x change ignored; 16 ring contacts saturate to 15
    obs_set.delete();
    for (int i = 0; i < 4; i++) begin
      obs_set[key(100 + i, 199)] = 1; obs_set[key(100 + i, 204)] = 1;
      obs_set[key(99, 200 + i)] = 1;  obs_set[key(104, 200 + i)] = 1;
    end
    chg_line = 100; chg_x = 300;
    clr(); window(95, 110, 100, 207);
    check("t5_pulses", n_coll, 16);
    chg_line = -1;
    clr(); blank();
    check("t5_hit_count_sat", hit_count, 15);
    check("t5_fp_once", n_fp, 1);
    check("t5_fp_latency", fp_cyc - t_fp0, 1);
    obs_set.delete(); obs_set[key(301, 199)] = 1;
    clr(); window(295, 310, 196, 207);
    check("t5_new_snap_top", n_top, 1);
    set_ball(100, 200);
    blank();
    check("t5_new_hit_count", hit_count, 1);

    // 6: reset while a right contact is in flight
    obs_set.delete(); obs_set[key(104, 201)] = 1; obs_set[key(99, 202)] = 1;
    rst_key = key(104, 201);
    clr(); window(95, 110, 196, 207);
    rst_key = -1;
    check("t6_after_reset", n_coll, 0);
    // Revisit the origin rows before any frame_pulse: a right contact against
    // the cleared (0,0) snapshot must stay suppressed.
    set_ball(0, 0);
    obs_set.delete(); obs_set[key(4, 1)] = 1;
    clr(); window(0, 8, 0, 5);
    check("t6_unarmed", n_coll, 0);
    blank();
    check("t6_hit_count", hit_count, 0);
    clr(); window(0, 8, 0, 5);
    check("t6_rearmed_right", n_right, 1);
    blank();
    check("t6_rearmed_hit_count", hit_count, 1);

    // Random frames; the first puts the right ring off-screen
    for (int f = 0; f < 6; f++) begin
      bx = (f == 0) ? 637 : int'($urandom_range(4, 620));
      by = int'($urandom_range(4, 470));
      set_ball(bx, by);
      blank();
      obs_set.delete();
      for (int y = by - 3; y <= by + 7; y++)
        for (int x = bx - 3; x <= bx + 7; x++)
          if ($urandom_range(0, 2) == 0) obs_set[key(x, y)] = 1;
      chg_line = by; chg_x = int'($urandom_range(0, 1023));
      window(bx - 3, bx + 7, by - 3, by + 7);
      chg_line = -1;
    end
    blank();
    drive(700, 481);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
